ltpi_dc_target_avmm_bridge: RTL and testbench
=============================================

// Module: ltpi_dc_target_avmm_bridge
// PURPOSE
//  Target-side end of the LTPI data channel: takes decoded read/write request frames from the link layer and
//  replays each as a single Avalon-MM master transaction into the target FPGA fabric. Returns one response frame
//  (tag, read data, status) per request to the link-layer encoder. One transaction outstanding at a time.
//  Counterpart of the controller-side AVMM target tunnel; sits between the frame decoder/encoder and avalon_mm_m.
// PARAMETERS
//  ADDR_W          32    Avalon address width
//  TIMEOUT_CYCLES  1024  max cycles from command issue to completion before a TIMEOUT response; >=2
//  TAG_W           8     request/response tag width
// PORTS
//  clk              in   1       system clock (clk_60MHZ domain)
//  reset_n          in   1       synchronous, active-low reset
//  link_up          in   1       link in operational_st; low aborts any transaction
//  req_valid        in   1       request frame valid
//  req_ready        out  1       bridge accepts request
//  req_cmd          in   dc_cmd_t  DC_RD / DC_WR
//  req_addr         in   ADDR_W  transaction address
//  req_wdata        in   32      write data
//  req_byteen       in   4       byte enables
//  req_tag          in   TAG_W   tag echoed in response
//  avm_address      out  ADDR_W  Avalon master address
//  avm_read         out  1       Avalon read
//  avm_write        out  1       Avalon write
//  avm_writedata    out  32      Avalon write data
//  avm_byteenable   out  4       Avalon byte enables
//  avm_waitrequest  in   1       Avalon waitrequest
//  avm_readdata     in   32      Avalon read data
//  avm_readdatavalid in  1       Avalon read data valid
//  rsp_valid        out  1       response frame valid
//  rsp_ready        in   1       encoder accepts response
//  rsp_cmd          out  dc_cmd_t  echoed command
//  rsp_tag          out  TAG_W   echoed tag
//  rsp_rdata        out  32      read data (0 for writes and errors)
//  rsp_status       out  dc_status_t  DC_OK / DC_TIMEOUT
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (req_ready=0, avm_read/write=0, rsp_valid=0, data/addr/tag/status 0).
//  - FSM IDLE -> ISSUE -> (WAIT_RD) -> RESP -> IDLE.
//  - IDLE: req_ready = link_up. On req_valid&req_ready: latch addr/wdata/byteen/tag/cmd; next cycle ISSUE with
//    avm_read or avm_write =1 (exactly one) and timeout counter cleared.
//  - ISSUE: hold all avm_* stable while avm_waitrequest=1. On accept (!waitrequest): drop read/write next cycle;
//    write -> RESP (DC_OK); read -> WAIT_RD, or straight to RESP if avm_readdatavalid in the accept cycle.
//  - WAIT_RD: on avm_readdatavalid capture avm_readdata -> RESP (DC_OK).
//  - Latency: write with waitrequest=0: rsp_valid 2 cycles after request handshake. Read with readdatavalid 1 cycle
//    after accept: rsp_valid 3 cycles after handshake.
//  - Timeout: counter increments each cycle in ISSUE/WAIT_RD; at TIMEOUT_CYCLES-1 deassert avm_read/write,
//    go RESP with DC_TIMEOUT, rsp_rdata=0. Completion and timeout in same cycle: completion wins (DC_OK).
//  - RESP: rsp_valid held with stable fields until rsp_ready; then IDLE. req_ready=0 outside IDLE.
//  - readdatavalid arriving in IDLE/RESP (late, post-timeout): ignored, no response generated.
//  - link_up=0 in any state: next cycle IDLE, avm_read/write=0, rsp_valid=0, transaction discarded, no response.
//  - Counter width $clog2(TIMEOUT_CYCLES)+1; saturates, never wraps.
// STRUCTURE
//  - ltpi_pkg: dc_cmd_t {DC_RD, DC_WR}, dc_status_t {DC_OK, DC_TIMEOUT}, dc_bridge_st_t {IDLE,ISSUE,WAIT_RD,RESP}.
//  - Single flat module; timeout counter inline, no sub-module.
// TESTING
//  - Write 0x1000 data 0xDEADBEEF be 0xF tag 0x5A, waitrequest=0 -> one avm_write cycle; rsp OK tag 0x5A rdata 0.
//  - Read 0x2004 tag 0x11, waitrequest 3 cycles, rdv 2 cycles later with 0xCAFEF00D -> avm_* stable; rsp OK 0xCAFEF00D.
//  - Read, TIMEOUT_CYCLES=16, no rdv -> avm_read drop at 16; rsp DC_TIMEOUT rdata 0; late rdv ignored.
//  - rsp_ready low 5 cycles -> rsp fields stable, req_ready=0 until handshake; back-to-back requests serialize.
//  - link_up drops in WAIT_RD -> IDLE next cycle, no rsp_valid; next request after link_up completes normally.
//  - reset_n low mid-ISSUE -> all outputs 0 on next edge, state IDLE.

Source files
------------

// File: rtl/ltpi_dc_target_avmm_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ltpi_dc_target_avmm_bridge_pkg
//   Shared types for the LTPI data-channel target-side Avalon-MM bridge:
//   request command, response status, bridge FSM state, fixed data widths and
//   a helper that sizes the timeout counter.
// ---------------------------------------------------------------------------
package ltpi_dc_target_avmm_bridge_pkg;

  typedef enum logic {
    DC_RD = 1'b0,
    DC_WR = 1'b1
  } dc_cmd_t;

  typedef enum logic {
    DC_OK      = 1'b0,
    DC_TIMEOUT = 1'b1
  } dc_status_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } dc_bridge_st_t;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // One extra bit beyond what TIMEOUT_CYCLES needs, so the counter can
  // saturate at its all-ones value without ever wrapping back to 0.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/ltpi_dc_target_avmm_bridge_if.sv
// ---------------------------------------------------------------------------
// ltpi_dc_target_avmm_bridge_if
//   Bundles the three buses around the bridge:
//     req_*  : decoded request frames from the link-layer decoder
//     avm_*  : Avalon-MM master into the target fabric
//     rsp_*  : response frames to the link-layer encoder
//   modport master : the bridge view (drives req_ready, avm_* commands, rsp_*)
//   modport slave  : the environment view (decoder, Avalon slave, encoder)
//
//   Handshake rule for req and rsp: a frame transfers on a rising clk edge
//   where valid and ready are both 1; once valid is raised, the sender keeps
//   valid and all payload fields stable until that edge. The Avalon side
//   follows Avalon-MM: a command is accepted on an edge where read/write is 1
//   and waitrequest is 0; read data is taken on an edge with readdatavalid 1.
// ---------------------------------------------------------------------------
interface ltpi_dc_target_avmm_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 8
);
  import ltpi_dc_target_avmm_bridge_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  dc_cmd_t               req_cmd;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [BE_W-1:0]       req_byteen;
  logic [TAG_W-1:0]      req_tag;

  logic [ADDR_W-1:0]     avm_address;
  logic                  avm_read;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic [BE_W-1:0]       avm_byteenable;
  logic                  avm_waitrequest;
  logic [DATA_W-1:0]     avm_readdata;
  logic                  avm_readdatavalid;

  logic                  rsp_valid;
  logic                  rsp_ready;
  dc_cmd_t               rsp_cmd;
  logic [TAG_W-1:0]      rsp_tag;
  logic [DATA_W-1:0]     rsp_rdata;
  dc_status_t            rsp_status;

  modport master (
    input  req_valid, req_cmd, req_addr, req_wdata, req_byteen, req_tag,
    output req_ready,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output rsp_valid, rsp_cmd, rsp_tag, rsp_rdata, rsp_status,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_cmd, req_addr, req_wdata, req_byteen, req_tag,
    input  req_ready,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  rsp_valid, rsp_cmd, rsp_tag, rsp_rdata, rsp_status,
    output rsp_ready
  );

endinterface

// File: rtl/ltpi_dc_target_avmm_bridge.sv
// ---------------------------------------------------------------------------
// ltpi_dc_target_avmm_bridge
//   Target-side end of the LTPI data channel. Each decoded request frame is
//   replayed as one Avalon-MM read or write; exactly one response frame
//   (cmd, tag, read data, status) is returned per request. One transaction in
//   flight at a time. A command that neither completes nor returns data within
//   TIMEOUT_CYCLES of issue is abandoned with a DC_TIMEOUT response.
//
//   Ports
//     clk        system clock
//     reset_n    synchronous, active-low reset
//     link_up    link operational; low discards any transaction, no response
//     bus        req/avm/rsp buses (master modport)
//     state_dbg  current FSM state
// ---------------------------------------------------------------------------
module ltpi_dc_target_avmm_bridge
  import ltpi_dc_target_avmm_bridge_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TAG_W          = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          link_up,
  ltpi_dc_target_avmm_bridge_if.master  bus,
  output dc_bridge_st_t                 state_dbg
);

  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  dc_bridge_st_t    state;
  logic             idle_rdy;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic [CNT_W-1:0] tmo_next;

  // idle_rdy is the registered "in IDLE and able to take a frame" flag; the
  // live link_up gate makes req_ready drop in the same cycle the link goes
  // down so no frame is accepted that will then be thrown away.
  assign bus.req_ready = idle_rdy & link_up;
  assign state_dbg     = state;

  assign tmo_hit  = (tmo_cnt >= CNT_LAST);
  assign tmo_next = (tmo_cnt == CNT_MAX) ? tmo_cnt : tmo_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= IDLE;
      idle_rdy           <= 1'b0;
      tmo_cnt            <= '0;
      bus.avm_address    <= '0;
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
      bus.avm_writedata  <= '0;
      bus.avm_byteenable <= '0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_cmd        <= DC_RD;
      bus.rsp_tag        <= '0;
      bus.rsp_rdata      <= '0;
      bus.rsp_status     <= DC_OK;
    end else if (!link_up) begin
      state         <= IDLE;
      idle_rdy      <= 1'b1;
      tmo_cnt       <= '0;
      bus.avm_read  <= 1'b0;
      bus.avm_write <= 1'b0;
      bus.rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idle_rdy <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            // rsp_cmd/rsp_tag double as the latched request cmd/tag; they
            // are not observed until rsp_valid rises.
            idle_rdy           <= 1'b0;
            tmo_cnt            <= '0;
            bus.avm_address    <= bus.req_addr;
            bus.avm_writedata  <= bus.req_wdata;
            bus.avm_byteenable <= bus.req_byteen;
            bus.avm_read       <= (bus.req_cmd == DC_RD);
            bus.avm_write      <= (bus.req_cmd == DC_WR);
            bus.rsp_cmd        <= bus.req_cmd;
            bus.rsp_tag        <= bus.req_tag;
            state              <= ISSUE;
          end
        end

        ISSUE: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_read  <= 1'b0;
            bus.avm_write <= 1'b0;
            if (bus.rsp_cmd == DC_WR) begin
              bus.rsp_rdata  <= '0;
              bus.rsp_status <= DC_OK;
              bus.rsp_valid  <= 1'b1;
              state          <= RESP;
            end else if (bus.avm_readdatavalid) begin
              // Slave returned data in the accept cycle itself.
              bus.rsp_rdata  <= bus.avm_readdata;
              bus.rsp_status <= DC_OK;
              bus.rsp_valid  <= 1'b1;
              state          <= RESP;
            end else if (tmo_hit) begin
              // Read accepted on the last allowed cycle with no data yet:
              // the transaction has not completed, so it times out.
              bus.rsp_rdata  <= '0;
              bus.rsp_status <= DC_TIMEOUT;
              bus.rsp_valid  <= 1'b1;
              state          <= RESP;
            end else begin
              tmo_cnt <= tmo_next;
              state   <= WAIT_RD;
            end
          end else if (tmo_hit) begin
            bus.avm_read   <= 1'b0;
            bus.avm_write  <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_status <= DC_TIMEOUT;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        WAIT_RD: begin
          if (bus.avm_readdatavalid) begin
            bus.rsp_rdata  <= bus.avm_readdata;
            bus.rsp_status <= DC_OK;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else if (tmo_hit) begin
            bus.rsp_rdata  <= '0;
            bus.rsp_status <= DC_TIMEOUT;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            idle_rdy      <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltpi_dc_target_avmm_bridge.sv
// ---------------------------------------------------------------------------
// tb_ltpi_dc_target_avmm_bridge
//   Directed bench for the LTPI DC target Avalon-MM bridge. A table of
//   transactions (request fields, Avalon slave behaviour, expected response
//   and timing) is replayed in a loop, followed by hand-written link-drop and
//   mid-transaction reset sequences. TIMEOUT_CYCLES is 16.
// ---------------------------------------------------------------------------
module tb_ltpi_dc_target_avmm_bridge;
  import ltpi_dc_target_avmm_bridge_pkg::*;

  localparam int ADDR_W = 32;
  localparam int TAG_W  = 8;
  localparam int TMO    = 16;

  // ---------------- clock / reset ----------------
  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          link_up = 1'b1;
  dc_bridge_st_t state_dbg;

  always #5 clk = ~clk;

  ltpi_dc_target_avmm_bridge_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

  ltpi_dc_target_avmm_bridge #(
    .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .link_up(link_up), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  // wait_n : cycles waitrequest is held after the command appears
  // rdv_dly: cycles from accept to readdatavalid (0 = same cycle, -1 = never)
  // exp_lat: cycles from request handshake edge to rsp_valid visible
  // exp_act_end: last cycle (1 = first command cycle) with avm_read/write high
  typedef struct {
    dc_cmd_t     cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  tag;
    int          wait_n;
    int          rdv_dly;
    logic [31:0] rdata;
    int          hold_n;
    int          exp_lat;
    dc_status_t  exp_status;
    logic [31:0] exp_rdata;
    int          exp_act_end;
  } vec_t;

  vec_t vecs[10];

  // ---------------- driver tasks ----------------
  task automatic send_req(input vec_t v, output bit ok);
    ok = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_cmd    = v.cmd;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_byteen = v.be;
    bus.req_tag    = v.tag;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("req_handshake", 64'(ok), 64'(1'b1));
    if (ok) step();
    bus.req_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string name);
    bit          ok;
    bit          got;
    bit          seq_ok;
    bit          stable_ok;
    bit          quiet_ok;
    bit          act;
    int          lat;
    logic [31:0] exp_rd;

    send_req(v, ok);
    if (!ok) return;
    exp_q.push_back(v.exp_rdata);

    got    = 1'b0;
    seq_ok = 1'b1;
    lat    = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      bus.avm_waitrequest = (cyc < 1 + v.wait_n);
      if (v.rdv_dly >= 0 && cyc == 1 + v.wait_n + v.rdv_dly) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = v.rdata;
      end else begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = 32'hDEAD0000 | 32'(cyc);
      end
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        lat = cyc;
        break;
      end
      act = (cyc <= v.exp_act_end);
      if (bus.avm_read  !== (act && v.cmd == DC_RD)) seq_ok = 1'b0;
      if (bus.avm_write !== (act && v.cmd == DC_WR)) seq_ok = 1'b0;
      if (act && (bus.avm_address !== v.addr || bus.avm_byteenable !== v.be)) seq_ok = 1'b0;
      if (act && v.cmd == DC_WR && bus.avm_writedata !== v.wdata) seq_ok = 1'b0;
      if (bus.req_ready !== 1'b0) seq_ok = 1'b0;
      step();
    end
    bus.avm_readdatavalid = 1'b0;
    bus.avm_waitrequest   = 1'b0;

    exp_rd = exp_q.pop_front();
    check({name, ".rsp_seen"}, 64'(got), 64'(1'b1));
    check({name, ".avm_seq"}, 64'(seq_ok), 64'(1'b1));
    if (!got) return;
    check({name, ".latency"}, 64'(lat), 64'(v.exp_lat));
    check({name, ".rsp_tag"}, 64'(bus.rsp_tag), 64'(v.tag));
    check({name, ".rsp_cmd"}, 64'(bus.rsp_cmd), 64'(v.cmd));
    check({name, ".rsp_status"}, 64'(bus.rsp_status), 64'(v.exp_status));
    check({name, ".rsp_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
    check({name, ".avm_idle_in_resp"}, 64'({bus.avm_read, bus.avm_write}), 64'(2'b00));

    // Hold the response with a stray readdatavalid each cycle; nothing may move.
    stable_ok = 1'b1;
    bus.rsp_ready = 1'b0;
    for (int h = 0; h < v.hold_n; h++) begin
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = 32'hFFFF0000 | 32'(h);
      step();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== v.tag || bus.rsp_rdata !== exp_rd ||
          bus.rsp_status !== v.exp_status || bus.req_ready !== 1'b0) stable_ok = 1'b0;
    end
    bus.avm_readdatavalid = 1'b0;
    if (v.hold_n > 0) check({name, ".rsp_stable"}, 64'(stable_ok), 64'(1'b1));

    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check({name, ".rsp_released"}, 64'(bus.rsp_valid), 64'(1'b0));
    check({name, ".req_ready_back"}, 64'(bus.req_ready), 64'(1'b1));

    // Late readdatavalid in IDLE must not produce a response.
    quiet_ok = 1'b1;
    for (int q = 0; q < 3; q++) begin
      bus.avm_readdatavalid = (q != 1);
      bus.avm_readdata      = 32'h5EED0000 | 32'(q);
      step();
      if (bus.rsp_valid !== 1'b0) quiet_ok = 1'b0;
    end
    bus.avm_readdatavalid = 1'b0;
    check({name, ".idle_quiet"}, 64'(quiet_ok), 64'(1'b1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit   ok;
    bit   quiet_ok;
    vec_t lv;

    //            cmd    addr          wdata         be    tag    wt  rdv rdata         hold lat status      exp_rdata     end
    vecs[0] = '{DC_WR, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 8'h5A, 0,  -1, 32'h0,        0,   2,  DC_OK,      32'h0,        1};
    vecs[1] = '{DC_RD, 32'h0000_2004, 32'h0,         4'hF, 8'h11, 3,  2,  32'hCAFE_F00D, 0,  7,  DC_OK,      32'hCAFE_F00D, 4};
    vecs[2] = '{DC_RD, 32'h0000_3000, 32'h0,         4'hF, 8'h22, 0,  0,  32'h1234_5678, 1,  2,  DC_OK,      32'h1234_5678, 1};
    vecs[3] = '{DC_WR, 32'h0000_3008, 32'h00C0_FFEE, 4'h3, 8'h33, 2,  -1, 32'h0,        5,   4,  DC_OK,      32'h0,        3};
    vecs[4] = '{DC_RD, 32'h0000_4000, 32'h0,         4'hF, 8'h44, 0,  1,  32'hA5A5_5A5A, 0,  3,  DC_OK,      32'hA5A5_5A5A, 1};
    vecs[5] = '{DC_RD, 32'h0000_5000, 32'h0,         4'hF, 8'h55, 100, -1, 32'h0,       2,   17, DC_TIMEOUT, 32'h0,        16};
    vecs[6] = '{DC_WR, 32'h0000_6000, 32'h1122_3344, 4'hC, 8'h66, 100, -1, 32'h0,       0,   17, DC_TIMEOUT, 32'h0,        16};
    vecs[7] = '{DC_RD, 32'h0000_7000, 32'h0,         4'hF, 8'h77, 0,  -1, 32'h0,        0,   17, DC_TIMEOUT, 32'h0,        1};
    vecs[8] = '{DC_RD, 32'h0000_8000, 32'h0,         4'hF, 8'h88, 15, 0,  32'h0BAD_F00D, 0,  17, DC_OK,      32'h0BAD_F00D, 16};
    vecs[9] = '{DC_WR, 32'h0000_9000, 32'h55AA_55AA, 4'hF, 8'h99, 15, -1, 32'h0,        0,   17, DC_OK,      32'h0,        16};

    bus.req_valid         = 1'b0;
    bus.req_cmd           = DC_RD;
    bus.req_addr          = '0;
    bus.req_wdata         = '0;
    bus.req_byteen        = '0;
    bus.req_tag           = '0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;
    bus.rsp_ready         = 1'b0;

    // Reset state: link is up, yet everything must read 0 while in reset.
    repeat (3) step();
    check("reset.req_ready", 64'(bus.req_ready), 64'(1'b0));
    check("reset.avm_rw", 64'({bus.avm_read, bus.avm_write}), 64'(2'b00));
    check("reset.rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    check("reset.avm_address", 64'(bus.avm_address), 64'(0));
    check("reset.rsp_fields", 64'({bus.rsp_tag, bus.rsp_rdata, bus.rsp_status}), 64'(0));
    check("reset.state", 64'(state_dbg), 64'(IDLE));
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Link drop while waiting for read data: discard, no response.
    lv = vecs[7];
    lv.tag = 8'hAB;
    send_req(lv, ok);
    bus.avm_waitrequest = 1'b0;
    step();
    check("linkdrop.in_wait_rd", 64'(state_dbg), 64'(WAIT_RD));
    link_up = 1'b0;
    step();
    check("linkdrop.state", 64'(state_dbg), 64'(IDLE));
    check("linkdrop.outputs", 64'({bus.avm_read, bus.avm_write, bus.rsp_valid, bus.req_ready}), 64'(4'b0000));
    link_up = 1'b1;
    quiet_ok = 1'b1;
    for (int q = 0; q < 24; q++) begin
      bus.avm_readdatavalid = (q == 3);
      step();
      if (bus.rsp_valid !== 1'b0) quiet_ok = 1'b0;
    end
    bus.avm_readdatavalid = 1'b0;
    check("linkdrop.no_rsp", 64'(quiet_ok), 64'(1'b1));
    run_txn(vecs[1], "after_linkdrop");

    // Reset in the middle of ISSUE.
    lv = vecs[6];
    lv.tag = 8'hCD;
    bus.avm_waitrequest = 1'b1;
    send_req(lv, ok);
    check("midreset.issuing", 64'({bus.avm_write, state_dbg}), 64'({1'b1, ISSUE}));
    step();
    reset_n = 1'b0;
    step();
    check("midreset.state", 64'(state_dbg), 64'(IDLE));
    check("midreset.outputs", 64'({bus.avm_read, bus.avm_write, bus.rsp_valid, bus.req_ready}), 64'(4'b0000));
    check("midreset.regs", 64'({bus.avm_address, bus.rsp_tag}), 64'(0));
    reset_n = 1'b1;
    bus.avm_waitrequest = 1'b0;
    step();
    run_txn(vecs[0], "after_reset");

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
